// File: rtl/hydra.sv
// hydra: sixteen-port store-and-forward packet switch over a shared slot buffer.
// Define HYDRA_PAUSE_EN to drive the occupancy-based pause output; otherwise pause is tied low.
module hydra #(
  parameter int unsigned NUM_SLOTS  = 32,
  parameter int unsigned SLOT_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       wr_sop,
  input  logic [15:0]       wr_vld,
  input  logic [15:0][15:0] wr_data,
  input  logic [15:0]       wr_eop,
  output logic [15:0]       pause,
  input  logic [15:0]       ready,
  output logic [15:0]       rd_sop,
  output logic [15:0]       rd_vld,
  output logic [15:0][15:0] rd_data,
  output logic [15:0]       rd_eop,
  input  logic [15:0]       wrr_enable,
  input  logic [4:0]        match_threshold,
  input  logic [1:0]        match_mode
);
  localparam int unsigned NP = 16;
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned CW = $clog2(SLOT_WORDS + 1);
  localparam int unsigned AW = $clog2(NUM_SLOTS * SLOT_WORDS);

  typedef enum logic {E_IDLE, E_XFER} estate_t;

  logic [NUM_SLOTS-1:0] s_busy, s_vld;
  logic [3:0]    s_dest  [NUM_SLOTS];
  logic [2:0]    s_prio  [NUM_SLOTS];
  logic [15:0]   s_stamp [NUM_SLOTS];
  logic [CW-1:0] s_words [NUM_SLOTS];

  logic [NP-1:0] i_open;
  logic [SW-1:0] i_slot [NP];
  logic [CW-1:0] i_cnt  [NP];
  logic [6:0]    i_tag  [NP];

  estate_t       e_state [NP];
  estate_t       e_state_nxt [NP];
  logic [NP-1:0] e_req;
  logic [SW-1:0] e_slot   [NP];
  logic [CW-1:0] e_idx    [NP];
  logic [2:0]    wrr_lvl  [NP];
  logic [3:0]    wrr_used [NP];
  logic [15:0]   arr_cnt;
  logic [SW-1:0] rot_ptr;

  logic [15:0] mem [NUM_SLOTS*SLOT_WORDS];

  logic [NUM_SLOTS-1:0] free_c;
  logic [SW-1:0] ptr_c;
  logic [NP-1:0] alloc_ok, wr_en_c, cmp_c, start_c, fin_c;
  logic [SW-1:0] alloc_slot [NP];
  logic [SW-1:0] sel_slot_c [NP];
  logic [2:0]    sel_lvl_c  [NP];
  logic [3:0]    wrr_u_c    [NP];
  logic [15:0]   stamp_c    [NP];
  logic [AW-1:0] waddr_c    [NP];
  logic [AW-1:0] raddr_c    [NP];
  logic [15:0]   arr_nxt_c, age, best_age;
  logic [7:0]    lvl_ne;
  logic          hit, have;

  function automatic int unsigned pick_idx(input logic [1:0] mode, input int unsigned ptr,
                                           input int unsigned k);
    case (mode)
      2'd1:    return NUM_SLOTS - 1 - k;
      2'd2:    return (ptr + k) % NUM_SLOTS;
      default: return k;
    endcase
  endfunction

  // Slot allocation: sops served in ascending port order, each removing its slot from the pool
  always_comb begin
    free_c = ~s_busy;
    ptr_c  = rot_ptr;
    alloc_ok = '0;
    for (int i = 0; i < NP; i++) begin
      alloc_slot[i] = '0;
      if (wr_sop[i]) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if (!alloc_ok[i] && free_c[SW'(pick_idx(match_mode, int'(ptr_c), k))]) begin
            alloc_ok[i]   = 1'b1;
            alloc_slot[i] = SW'(pick_idx(match_mode, int'(ptr_c), k));
          end
        end
        if (alloc_ok[i]) begin
          free_c[alloc_slot[i]] = 1'b0;
          ptr_c = SW'((int'(alloc_slot[i]) + 1) % NUM_SLOTS);
        end
      end
    end
  end

  // Ingress word writes and packet completion; simultaneous completions take consecutive stamps
  always_comb begin
    arr_nxt_c = arr_cnt;
    for (int i = 0; i < NP; i++) begin
      wr_en_c[i] = i_open[i] && !wr_sop[i] && !wr_eop[i] && wr_vld[i] &&
                   (i_cnt[i] < CW'(SLOT_WORDS));
      cmp_c[i]   = i_open[i] && !wr_sop[i] && wr_eop[i] && (i_cnt[i] != '0);
      stamp_c[i] = arr_nxt_c;
      waddr_c[i] = AW'(int'(i_slot[i]) * SLOT_WORDS + int'(i_cnt[i]));
      if (cmp_c[i]) arr_nxt_c = arr_nxt_c + 16'd1;
    end
  end

  // Egress scheduler: pick a level (strict or WRR), then the oldest packet at that level
  always_comb begin
    lvl_ne = '0; hit = 1'b0; have = 1'b0; age = '0; best_age = '0;
    for (int p = 0; p < NP; p++) begin
      e_state_nxt[p] = e_state[p];
      start_c[p]     = 1'b0;
      fin_c[p]       = 1'b0;
      sel_slot_c[p]  = '0;
      sel_lvl_c[p]   = '0;
      raddr_c[p]     = AW'(int'(e_slot[p]) * SLOT_WORDS + int'(e_idx[p]));
      lvl_ne = '0;
      for (int s = 0; s < NUM_SLOTS; s++)
        if (s_vld[s] && s_dest[s] == 4'(p)) lvl_ne[s_prio[s]] = 1'b1;
      hit = 1'b0;
      if (wrr_enable[p]) begin
        for (int k = 0; k < 8; k++)
          if (!hit && lvl_ne[wrr_lvl[p] - 3'(k)]) begin
            hit = 1'b1;
            sel_lvl_c[p] = wrr_lvl[p] - 3'(k);
          end
      end else begin
        for (int k = 0; k < 8; k++)
          if (lvl_ne[k]) begin
            hit = 1'b1;
            sel_lvl_c[p] = 3'(k);
          end
      end
      wrr_u_c[p] = (sel_lvl_c[p] == wrr_lvl[p]) ? wrr_used[p] + 4'd1 : 4'd1;
      have = 1'b0;
      best_age = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (s_vld[s] && s_dest[s] == 4'(p) && s_prio[s] == sel_lvl_c[p]) begin
          age = arr_cnt - s_stamp[s];
          if (!have || age > best_age) begin
            have = 1'b1;
            best_age = age;
            sel_slot_c[p] = SW'(s);
          end
        end
      end
      case (e_state[p])
        E_IDLE: if (e_req[p] && hit) begin
          start_c[p] = 1'b1;
          e_state_nxt[p] = E_XFER;
        end
        E_XFER: if (e_idx[p] == s_words[e_slot[p]]) begin
          fin_c[p] = 1'b1;
          e_state_nxt[p] = E_IDLE;
        end
        default: e_state_nxt[p] = E_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int p = 0; p < NP; p++) e_state[p] <= E_IDLE;
    else        for (int p = 0; p < NP; p++) e_state[p] <= e_state_nxt[p];
  end

  // Packet buffer storage; contents need no reset since slot state gates every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++)
      if (wr_en_c[i]) mem[waddr_c[i]] <= wr_data[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_busy <= '0; s_vld <= '0; i_open <= '0; e_req <= '0;
      arr_cnt <= '0; rot_ptr <= '0;
      rd_sop <= '0; rd_vld <= '0; rd_eop <= '0; rd_data <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        s_dest[s] <= '0; s_prio[s] <= '0; s_stamp[s] <= '0; s_words[s] <= '0;
      end
      for (int p = 0; p < NP; p++) begin
        i_slot[p] <= '0; i_cnt[p] <= '0; i_tag[p] <= '0;
        e_slot[p] <= '0; e_idx[p] <= '0;
        wrr_lvl[p] <= 3'd7; wrr_used[p] <= '0;
      end
    end else begin
      rd_sop <= '0; rd_vld <= '0; rd_eop <= '0; rd_data <= '0;
      arr_cnt <= arr_nxt_c;
      rot_ptr <= ptr_c;
      for (int p = 0; p < NP; p++) begin
        e_req[p] <= ready[p] | (e_req[p] & ~start_c[p]);
        if (start_c[p]) begin
          rd_sop[p] <= 1'b1;
          e_slot[p] <= sel_slot_c[p];
          e_idx[p]  <= '0;
          s_vld[sel_slot_c[p]] <= 1'b0;
          if (wrr_enable[p]) begin
            if (wrr_u_c[p] > {1'b0, sel_lvl_c[p]}) begin
              wrr_lvl[p]  <= sel_lvl_c[p] - 3'd1;
              wrr_used[p] <= '0;
            end else begin
              wrr_lvl[p]  <= sel_lvl_c[p];
              wrr_used[p] <= wrr_u_c[p];
            end
          end
        end else if (fin_c[p]) begin
          rd_eop[p] <= 1'b1;
          s_busy[e_slot[p]] <= 1'b0;
        end else if (e_state[p] == E_XFER) begin
          rd_vld[p]  <= 1'b1;
          rd_data[p] <= mem[raddr_c[p]];
          e_idx[p]   <= e_idx[p] + CW'(1);
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (wr_sop[i]) begin
          if (i_open[i]) s_busy[i_slot[i]] <= 1'b0;
          i_open[i] <= alloc_ok[i];
          i_cnt[i]  <= '0;
          if (alloc_ok[i]) begin
            i_slot[i] <= alloc_slot[i];
            s_busy[alloc_slot[i]] <= 1'b1;
          end
        end else if (i_open[i] && wr_eop[i]) begin
          i_open[i] <= 1'b0;
          if (cmp_c[i]) begin
            s_vld[i_slot[i]]   <= 1'b1;
            s_dest[i_slot[i]]  <= i_tag[i][3:0];
            s_prio[i_slot[i]]  <= i_tag[i][6:4];
            s_stamp[i_slot[i]] <= stamp_c[i];
            s_words[i_slot[i]] <= i_cnt[i];
          end else begin
            s_busy[i_slot[i]] <= 1'b0;
          end
        end else if (wr_en_c[i]) begin
          i_cnt[i] <= i_cnt[i] + CW'(1);
          if (i_cnt[i] == '0) i_tag[i] <= wr_data[i][6:0];
        end
      end
    end
  end

`ifdef HYDRA_PAUSE_EN
  // Occupancy counts open and completed slots alike
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pause <= '0;
    else        pause <= ($countones(s_busy) >= int'(match_threshold)) ? 16'hFFFF : 16'h0000;
  end
`else
  logic unused_thr;
  assign unused_thr = ^match_threshold;
  assign pause = '0;
`endif

endmodule

// File: tb/tb_hydra.sv
// tb_hydra: directed self-checking bench for the hydra packet switch.
// Covers reset, single packet framing, WRR and strict ordering, pause, buffer full and mid-egress reset.
module tb_hydra;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       wr_sop, wr_vld, wr_eop, pause, ready, rd_sop, rd_vld, rd_eop, wrr_enable;
  logic [15:0][15:0] wr_data, rd_data;
  logic [4:0]        match_threshold;
  logic [1:0]        match_mode;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] got_w [1024];

`ifdef HYDRA_PAUSE_EN
  localparam logic [15:0] PAUSE_ON = 16'hFFFF;
`else
  localparam logic [15:0] PAUSE_ON = 16'h0000;
`endif

  localparam logic [15:0] MIX_H  [6] = '{16'h0FC3, 16'h1BB3, 16'h1BB3, 16'h1BB3, 16'h1B33, 16'h4053};
  localparam logic [15:0] EXP_H  [6] = '{16'h4053, 16'h0FC3, 16'h1BB3, 16'h1BB3, 16'h1BB3, 16'h1B33};
  localparam logic [15:0] EXP_W1 [6] = '{16'h5000, 16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000};

  hydra dut (
    .clk(clk), .rst_n(rst_n),
    .wr_sop(wr_sop), .wr_vld(wr_vld), .wr_data(wr_data), .wr_eop(wr_eop),
    .pause(pause), .ready(ready),
    .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_data(rd_data), .rd_eop(rd_eop),
    .wrr_enable(wrr_enable), .match_threshold(match_threshold), .match_mode(match_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic send(input int port, input logic [15:0] hdr, input int n, input logic [15:0] base);
    @(negedge clk); wr_sop[port] = 1'b1;
    @(negedge clk); wr_sop[port] = 1'b0; wr_vld[port] = 1'b1; wr_data[port] = hdr;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); wr_data[port] = base + 16'(k);
    end
    @(negedge clk); wr_vld[port] = 1'b0; wr_eop[port] = 1'b1; wr_data[port] = '0;
    @(negedge clk); wr_eop[port] = 1'b0;
  endtask

  task automatic pulse(input int p);
    @(negedge clk); ready[p] = 1'b1;
    @(negedge clk); ready[p] = 1'b0;
  endtask

  // Waits (bounded) for rd_sop on egress p, then captures the word stream and checks the eop
  task automatic recv(input int p, input int tmo, output logic ok, output logic [15:0] hdr,
                      output int nw);
    ok = 1'b0; hdr = '0; nw = 0;
    for (int c = 0; c < tmo && !ok; c++) begin
      @(negedge clk);
      if (rd_sop[p]) ok = 1'b1;
    end
    if (ok) begin
      @(negedge clk);
      while (rd_vld[p] && nw < 1024) begin
        got_w[nw] = rd_data[p];
        nw++;
        @(negedge clk);
      end
      hdr = got_w[0];
      chk("eop", 32'(rd_eop[p]), 32'd1);
    end
  endtask

  task automatic send_mix();
    logic [15:0] h;
    for (int j = 0; j < 6; j++) begin
      h = MIX_H[j];
      send(0, h, int'(h[15:7]), 16'(j << 12));
    end
  endtask

  task automatic check_mix(input string name);
    logic ok;
    logic [15:0] hdr, h;
    int nw;
    for (int j = 0; j < 6; j++) begin
      pulse(3);
      recv(3, 200, ok, hdr, nw);
      h = EXP_H[j];
      chk($sformatf("%s_ok%0d", name, j), 32'(ok), 32'd1);
      chk($sformatf("%s_hdr%0d", name, j), 32'(hdr), 32'(h));
      chk($sformatf("%s_len%0d", name, j), 32'(nw), 32'(h[15:7]) + 32'd1);
      chk($sformatf("%s_w1_%0d", name, j), 32'(got_w[1]), 32'(EXP_W1[j]));
    end
  endtask

  initial begin
    logic ok;
    logic [15:0] hdr;
    int nw, cnt, seen;
    rst_n = 1'b0;
    wr_sop = '0; wr_vld = '0; wr_eop = '0; wr_data = '0; ready = '0;
    wrr_enable = '0; match_threshold = 5'd30; match_mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_sop", 32'(rd_sop), 32'd0);
    chk("rst_vld", 32'(rd_vld), 32'd0);
    chk("rst_eop", 32'(rd_eop), 32'd0);
    chk("rst_data", 32'(|rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single packet framing
    send(0, 16'h0FC3, 31, 16'h0000);
    repeat (3) @(negedge clk);
    pulse(3);
    recv(3, 100, ok, hdr, nw);
    chk("single_ok", 32'(ok), 32'd1);
    chk("single_len", 32'(nw), 32'd32);
    chk("single_hdr", 32'(got_w[0]), 32'h0FC3);
    for (int k = 0; k < 31; k++) chk($sformatf("single_w%0d", k + 1), 32'(got_w[k + 1]), 32'(k));

    // WRR then strict priority on identical traffic
    wrr_enable = 16'hFFFF; match_mode = 2'd2;
    send_mix();
    check_mix("wrr");
    wrr_enable = 16'h0000;
    send_mix();
    check_mix("sp");

    // Pause threshold
    match_mode = 2'd0; match_threshold = 5'd2;
    send(0, 16'h0095, 1, 16'h0000);
    repeat (2) @(negedge clk);
    chk("pause_one", 32'(pause), 32'd0);
    send(0, 16'h0095, 1, 16'h0001);
    repeat (2) @(negedge clk);
    chk("pause_two", 32'(pause), 32'(PAUSE_ON));
    pulse(5);
    recv(5, 50, ok, hdr, nw);
    chk("pause_rd_ok", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    chk("pause_after", 32'(pause), 32'd0);
    pulse(5);
    recv(5, 50, ok, hdr, nw);
    chk("pause_rd2_ok", 32'(ok), 32'd1);
    match_threshold = 5'd30;

    // Buffer full: one more packet than slots
    match_mode = 2'd1;
    for (int j = 0; j < 33; j++) send(1, 16'h0086, 1, 16'(j));
    cnt = 0;
    for (int j = 0; j < 33; j++) begin
      pulse(6);
      recv(6, 30, ok, hdr, nw);
      if (ok) cnt++;
    end
    chk("full_cnt", 32'(cnt), 32'd32);

    // Reset in the middle of an egress transfer
    match_mode = 2'd0;
    send(2, 16'h3213, 100, 16'h0000);
    pulse(3);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (rd_sop[3]) ok = 1'b1;
    end
    chk("mid_sop", 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    chk("mid_vld", 32'(rd_vld[3]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(rd_vld), 32'd0);
    chk("mid_rst_data", 32'(|rd_data), 32'd0);
    chk("mid_rst_sop", 32'(rd_sop), 32'd0);
    chk("mid_rst_eop", 32'(rd_eop), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    pulse(3);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (|rd_sop || |rd_vld) seen++;
    end
    chk("post_rst_idle", 32'(seen), 32'd0);
    send(2, 16'h0093, 1, 16'h00AB);
    recv(3, 50, ok, hdr, nw);
    chk("held_req_ok", 32'(ok), 32'd1);
    chk("held_req_hdr", 32'(hdr), 32'h0093);
    chk("held_req_len", 32'(nw), 32'd2);
    chk("held_req_w1", 32'(got_w[1]), 32'h00AB);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
